// File: rtl/debug_pkg.sv
// Shared debug-link definitions: scheduler state encoding, frame header tag
// and the command codes carried by debugger frames.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } tx_state_e;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  localparam logic [7:0] CMD_RD_REG  = 8'h01;
  localparam logic [7:0] CMD_WR_REG  = 8'h02;
  localparam logic [7:0] CMD_RD_MEM  = 8'h03;
  localparam logic [7:0] CMD_STATUS  = 8'h04;

  function automatic logic [7:0] hdr_tag(input logic [3:0] id);
    return {HDR_NIBBLE, id};
  endfunction

endpackage

// File: rtl/debug_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_valid
);

  // Scan from farthest to nearest offset so the closest request wins last.
  always_comb begin
    o_grant_id = '0;
    o_valid    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[(int'(i_ptr) + i) % N]) begin
        o_grant_id = ID_W'((int'(i_ptr) + i) % N);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_tx_scheduler.sv
// Frames requester payloads (header tag + len bytes) onto a byte UART,
// granting requesters round-robin.
//   state | meaning
//   IDLE  | arbitrate pending requests
//   LOAD  | register header tag or payload byte
//   SEND  | one-cycle UART start pulse
//   WAIT  | wait for byte completion, honour abort
//   DONE  | pulse o_done for the granted requester
module debug_tx_scheduler
  import debug_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_len,
  input  logic [7:0]               i_byte,
  input  logic                     i_abort,
  input  logic                     i_tx_done,
  output logic                     o_tx_start,
  output logic [7:0]               o_tx_data,
  output logic [ID_W-1:0]          o_grant_id,
  output logic [LEN_W-1:0]         o_byte_idx,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy
);

  tx_state_e          state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   byte_idx_q, byte_idx_d;
  logic               hdr_q, hdr_d;
  logic               abort_q, abort_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] done_mask_q, done_mask_d;
  logic [NUM_REQ-1:0] done_vec;
  logic [ID_W-1:0]    ptr_next;
  logic [ID_W-1:0]    arb_id;
  logic               arb_valid;

  // A requester just signalled done may still hold i_req for one cycle.
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req      (i_req & ~done_mask_q),
    .i_ptr      (rr_ptr_q),
    .o_grant_id (arb_id),
    .o_valid    (arb_valid)
  );

  always_comb begin
    done_vec = (state_q == ST_DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    ptr_next = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    hdr_d       = hdr_q;
    abort_d     = abort_q | i_abort;
    tx_data_d   = tx_data_q;
    done_mask_d = done_vec;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (arb_valid) begin
          grant_d    = arb_id;
          len_d      = i_len[int'(arb_id)*LEN_W +: LEN_W];
          hdr_d      = 1'b1;
          byte_idx_d = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_data_d = hdr_q ? hdr_tag(4'(grant_q)) : i_byte;
        state_d   = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (abort_q || i_abort) begin
            rr_ptr_d = ptr_next;
            abort_d  = 1'b0;
            state_d  = ST_IDLE;
          end else if ((hdr_q && len_q == '0) ||
                       (!hdr_q && byte_idx_q == len_q - LEN_W'(1))) begin
            state_d = ST_DONE;
          end else begin
            if (hdr_q) hdr_d = 1'b0;
            else       byte_idx_d = byte_idx_q + LEN_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        rr_ptr_d = ptr_next;
        abort_d  = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      len_q       <= '0;
      byte_idx_q  <= '0;
      hdr_q       <= 1'b0;
      abort_q     <= 1'b0;
      tx_data_q   <= '0;
      done_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      hdr_q       <= hdr_d;
      abort_q     <= abort_d;
      tx_data_q   <= tx_data_d;
      done_mask_q <= done_mask_d;
    end
  end

  assign o_tx_start = (state_q == ST_SEND);
  assign o_tx_data  = tx_data_q;
  assign o_grant_id = grant_q;
  assign o_byte_idx = byte_idx_q;
  assign o_done     = done_vec;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Scoreboard bench for debug_tx_scheduler: expected bytes and done pulses are
// queued as requests are issued and checked as the scheduler emits them.
module tb_debug_tx_scheduler;

  localparam int NR = 4;
  localparam int LW = 8;
  localparam int IW = 2;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic [NR-1:0]    i_req = '0;
  logic [NR*LW-1:0] i_len = '0;
  logic [7:0]       i_byte;
  logic             i_abort = 1'b0;
  logic             i_tx_done;
  logic             o_tx_start;
  logic [7:0]       o_tx_data;
  logic [IW-1:0]    o_grant_id;
  logic [LW-1:0]    o_byte_idx;
  logic [NR-1:0]    o_done;
  logic             o_busy;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign i_tx_done = resp_done | spur_done;

  logic [7:0] mem [NR][256];
  assign i_byte = mem[o_grant_id][o_byte_idx];

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int resp_cnt = 0;
  logic [7:0]    exp_q[$];
  logic [NR-1:0] exp_done_q[$];
  logic [7:0]    exp_b;
  logic [NR-1:0] exp_d;

  always #5 i_clk = ~i_clk;

  debug_tx_scheduler #(.NUM_REQ(NR), .LEN_W(LW), .ID_W(IW)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_len      (i_len),
    .i_byte     (i_byte),
    .i_abort    (i_abort),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_grant_id (o_grant_id),
    .o_byte_idx (o_byte_idx),
    .o_done     (o_done),
    .o_busy     (o_busy)
  );

  // UART model: byte completes ~10 cycles after its start pulse.
  initial forever begin
    @(negedge i_clk);
    resp_done = 1'b0;
    if (i_reset) resp_cnt = 0;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end else if (o_tx_start) resp_cnt = 10;
  end

  // Output monitor: pops the scoreboard on every start pulse and done pulse.
  initial forever begin
    @(negedge i_clk);
    if (o_tx_start === 1'b1) begin
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte: got %h, expected no transmission", o_tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (o_tx_data !== exp_b) begin
          errors++;
          $display("FAIL tx_byte: got %h, expected %h", o_tx_data, exp_b);
        end
      end
    end
    if (o_done !== '0) begin
      done_cnt++;
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_pulse: got %b, expected no done", o_done);
      end else begin
        exp_d = exp_done_q.pop_front();
        if (o_done !== exp_d) begin
          errors++;
          $display("FAIL done_pulse: got %b, expected %b", o_done, exp_d);
        end
      end
    end
  end

  task automatic wait_cnt(input bit use_done, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      #1;
      if ((use_done ? done_cnt : start_cnt) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_req = '0;
    i_abort = 1'b0;
    spur_done = 1'b0;
    repeat (2) @(negedge i_clk);
    exp_q.delete();
    exp_done_q.delete();
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic push_frame(input int k, input int len);
    exp_q.push_back({4'hA, 4'(k)});
    for (int i = 0; i < len; i++) exp_q.push_back(mem[k][i]);
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_done !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b start=%b done=%b, expected 0 0 0", o_busy, o_tx_start, o_done);
    end
    checks++;
    if (o_tx_data !== 8'h00 || o_grant_id !== '0 || o_byte_idx !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h grant=%0d idx=%0d, expected 0 0 0", o_tx_data, o_grant_id, o_byte_idx);
    end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_single();
    int n = 0;
    int d0;
    bit ok;
    d0 = done_cnt;
    i_len[0 +: 8] = 8'd2;
    push_frame(0, 2);
    exp_done_q.push_back(4'b0001);
    i_req = 4'b0001;
    // Request seen in IDLE, then LOAD, then SEND: start visible 2 negedges later.
    do begin
      @(negedge i_clk);
      n++;
    end while (o_tx_start !== 1'b1 && n < 10);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL latency: got start after %0d cycles, expected 2", n);
    end
    wait_cnt(1'b1, d0 + 1, 300, ok);
    i_req = '0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: got no done, expected done within 300 cycles");
    end
    repeat (20) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL single_count: got %0d bytes pending, %0d dones, expected 0, 1", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_zero_len();
    int d0;
    bit ok;
    d0 = done_cnt;
    i_len[16 +: 8] = 8'd0;
    push_frame(2, 0);
    exp_done_q.push_back(4'b0100);
    i_req = 4'b0100;
    wait_cnt(1'b1, d0 + 1, 100, ok);
    i_req = '0;
    repeat (20) @(negedge i_clk);
    checks++;
    if (!ok || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL zero_len: got ok=%b pending=%0d dones=%0d, expected 1 0 1", ok, exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_round_robin();
    int d0;
    bit ok;
    do_reset();
    d0 = done_cnt;
    for (int k = 0; k < NR; k++) i_len[k*8 +: 8] = 8'd1;
    push_frame(0, 1); exp_done_q.push_back(4'b0001);
    push_frame(1, 1); exp_done_q.push_back(4'b0010);
    push_frame(3, 1); exp_done_q.push_back(4'b1000);
    push_frame(0, 1); exp_done_q.push_back(4'b0001);
    i_req = 4'b1011;
    wait_cnt(1'b1, d0 + 4, 400, ok);
    i_req = '0;
    repeat (20) @(negedge i_clk);
    checks++;
    if (!ok || exp_q.size() != 0 || done_cnt != d0 + 4) begin
      errors++;
      $display("FAIL round_robin: got ok=%b pending=%0d dones=%0d, expected 1 0 4", ok, exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int d0;
    int s0;
    bit ok;
    do_reset();
    d0 = done_cnt;
    s0 = start_cnt;
    i_len[8 +: 8] = 8'd4;
    i_len[24 +: 8] = 8'd1;
    exp_q.push_back(8'hA1);
    exp_q.push_back(mem[1][0]);
    exp_q.push_back(mem[1][1]);
    push_frame(3, 1);
    exp_done_q.push_back(4'b1000);
    i_req = 4'b1010;
    wait_cnt(1'b0, s0 + 3, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_start: got %0d starts, expected 3", start_cnt - s0);
    end
    repeat (3) @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    wait_cnt(1'b1, d0 + 1, 300, ok);
    i_req = '0;
    repeat (20) @(negedge i_clk);
    checks++;
    if (!ok || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL abort: got ok=%b pending=%0d dones=%0d, expected 1 0 1", ok, exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    int s0;
    bit ok;
    do_reset();
    d0 = done_cnt;
    s0 = start_cnt;
    i_len[16 +: 8] = 8'd2;
    push_frame(2, 2);
    i_req = 4'b0100;
    wait_cnt(1'b0, s0 + 3, 200, ok);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    checks++;
    if (!ok || o_busy !== 1'b0 || o_tx_start !== 1'b0 || o_done !== '0) begin
      errors++;
      $display("FAIL midreset_ctrl: got ok=%b busy=%b start=%b done=%b, expected 1 0 0 0", ok, o_busy, o_tx_start, o_done);
    end
    checks++;
    if (o_tx_data !== 8'h00 || o_grant_id !== '0 || o_byte_idx !== '0) begin
      errors++;
      $display("FAIL midreset_data: got data=%h grant=%0d idx=%0d, expected 0 0 0", o_tx_data, o_grant_id, o_byte_idx);
    end
    @(negedge i_clk);
    exp_q.delete();
    push_frame(2, 2);
    exp_done_q.push_back(4'b0100);
    i_reset = 1'b0;
    wait_cnt(1'b1, d0 + 1, 300, ok);
    i_req = '0;
    repeat (20) @(negedge i_clk);
    checks++;
    if (!ok || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL midreset_restart: got ok=%b pending=%0d dones=%0d, expected 1 0 1", ok, exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_spurious();
    int d0;
    bit ok;
    do_reset();
    d0 = done_cnt;
    i_len[16 +: 8] = 8'd2;
    spur_done = 1'b1;
    @(negedge i_clk);
    spur_done = 1'b0;
    push_frame(2, 2);
    exp_done_q.push_back(4'b0100);
    i_req = 4'b0100;
    @(negedge i_clk);
    spur_done = 1'b1;
    i_len[16 +: 8] = 8'd5;
    @(negedge i_clk);
    spur_done = 1'b0;
    wait_cnt(1'b1, d0 + 1, 300, ok);
    i_req = '0;
    repeat (20) @(negedge i_clk);
    checks++;
    if (!ok || exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL spurious: got ok=%b pending=%0d dones=%0d, expected 1 0 1", ok, exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_max_len();
    int d0;
    bit ok = 1'b0;
    int max_idx = 0;
    do_reset();
    d0 = done_cnt;
    i_len[24 +: 8] = 8'd255;
    push_frame(3, 255);
    exp_done_q.push_back(4'b1000);
    i_req = 4'b1000;
    for (int c = 0; c < 6000; c++) begin
      @(negedge i_clk);
      #1;
      if (o_busy && int'(o_byte_idx) > max_idx) max_idx = int'(o_byte_idx);
      if (done_cnt >= d0 + 1) begin
        ok = 1'b1;
        break;
      end
    end
    i_req = '0;
    repeat (20) @(negedge i_clk);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL max_len: got ok=%b pending=%0d, expected 1 0", ok, exp_q.size());
    end
    checks++;
    if (max_idx != 254) begin
      errors++;
      $display("FAIL max_len_idx: got max byte_idx %0d, expected 254", max_idx);
    end
  endtask

  initial begin
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < 256; i++) mem[k][i] = 8'((k + 1) * 16 + i + 1);
    mem[0][0] = 8'h11;
    mem[0][1] = 8'h22;
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_spurious();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_tx_scheduler.md
DEBUG_TX_SCHEDULER -- requirements
Module: debug_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of frame requesters (registers, latches, data memory, status).
REQ-002 SHALL have parameter LEN_W, default 8, width of per-requester payload byte count.
REQ-003 SHALL have parameter ID_W, default $clog2(NUM_REQ), requester index width.
REQ-004 i_clk  input  1  system clock, all logic on rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  NUM_REQ  per-requester frame request level, held until matching o_done.
REQ-007 i_len  input  NUM_REQ*LEN_W  packed payload byte counts, slice k for requester k.
REQ-008 i_byte  input  8  payload byte from external mux addressed by o_grant_id/o_byte_idx, combinational.
REQ-009 i_abort  input  1  drop current frame at next byte boundary.
REQ-010 i_tx_done  input  1  one-cycle pulse from UART transmitter when a byte finishes.
REQ-011 o_tx_start  output  1  one-cycle pulse, start UART transmission of o_tx_data.
REQ-012 o_tx_data  output  8  byte to transmit, stable from o_tx_start until next LOAD.
REQ-013 o_grant_id  output  ID_W  index of granted requester.
REQ-014 o_byte_idx  output  LEN_W  payload byte index currently fetched (0 = LSB byte).
REQ-015 o_done  output  NUM_REQ  one-hot one-cycle pulse, frame k completed.
REQ-016 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-017 States SHALL be IDLE, LOAD, SEND, WAIT, DONE.
REQ-018 IDLE: when any i_req bit set (not in-flight-complete), SHALL grant by round-robin starting at pointer rr_ptr, latch len, set header flag, byte_idx=0, go LOAD next cycle.
REQ-019 Requests whose o_done pulsed in the same cycle SHALL be ignored in IDLE for that cycle only.
REQ-020 LOAD: SHALL register o_tx_data = header tag {4'hA, grant id zero-extended to 4 bits} for header, else i_byte; go SEND.
REQ-021 SEND: SHALL assert o_tx_start for exactly one cycle; go WAIT.
REQ-022 WAIT: on i_tx_done, if i_abort high -> IDLE without o_done; else if header sent and len==0 or byte_idx==len-1 -> DONE; else advance (clear header flag or byte_idx+1) and go LOAD.
REQ-023 Every frame SHALL be 1 header byte followed by exactly len payload bytes, byte_idx 0..len-1 in order.
REQ-024 DONE: SHALL pulse o_done[grant] one cycle, set rr_ptr = grant+1 modulo NUM_REQ, go IDLE.
REQ-025 Abort SHALL also set rr_ptr = grant+1; i_abort in LOAD/SEND SHALL let the current byte complete first.
REQ-026 Latency: i_req rise in IDLE to first o_tx_start SHALL be 3 cycles (IDLE, LOAD, SEND).
REQ-027 i_tx_done outside WAIT SHALL be ignored; i_req deassertion mid-frame SHALL be ignored.
REQ-028 i_len changes after grant SHALL not affect the in-flight frame.
REQ-029 len=2^LEN_W-1 SHALL send 255 payload bytes with no byte_idx wrap.

Reset
REQ-030 On i_reset SHALL enter IDLE immediately, including mid-frame, dropping frame without o_done.
REQ-031 Reset values: o_tx_start=0, o_tx_data=0, o_grant_id=0, o_byte_idx=0, o_done=0, o_busy=0, rr_ptr=0.

Structure
REQ-032 State encoding localparams and header nibble 4'hA SHALL live in shared package debug_pkg with debugger command codes.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in, grant id and valid out, combinational).
REQ-034 No other sub-modules; UART and baud generator instantiated by parent.

Verification
REQ-035 Single request: i_req=4'b0001, len0=2, bytes 0x11,0x22, i_tx_done 10 cycles after each start -> tx sequence 0xA0,0x11,0x22, o_done=4'b0001 once.
REQ-036 Zero length: i_req=4'b0100, len2=0 -> single byte 0xA2 then o_done=4'b0100.
REQ-037 Round-robin: i_req=4'b1011 held, rr_ptr=0, len=1 each -> headers 0xA0,0xA1,0xA3,0xA0 in order.
REQ-038 Abort: len=4, i_abort pulsed during second payload byte's WAIT -> 3 bytes sent, no o_done, next grant from following requester.
REQ-039 Reset mid-frame: i_reset asserted in WAIT -> o_busy=0 same cycle, all outputs at reset values, no o_done; new request restarts at header.
REQ-040 Spurious i_tx_done in IDLE/LOAD and i_len change after grant -> no effect on sequence or count.
